// File: rtl/rc4_decrypt_fsm.sv
// rc4_decrypt_fsm: RC4 keystream generator (PRGA) and message decryptor.
// Reads S-RAM and the encrypted ROM, swaps S entries, XORs keystream into the decrypted RAM.
// Ports: clk, reset (async, active-low), start/fin handshake,
//        s_addr/s_wdata/s_wren/s_rdata (S-RAM), enc_addr/enc_rdata (ROM),
//        dec_addr/dec_wdata/dec_wren (decrypted RAM).
module rc4_decrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              fin,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_rdata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wdata,
  output logic              dec_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    CAP_SI,
    RD_SJ,
    CAP_SJ,
    WR_I,
    WR_J,
    RD_F,
    CAP_F,
    WR_D,
    DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t state, state_nx;

  logic [7:0] i, i_nx;
  logic [7:0] j, j_nx;
  logic [7:0] si, si_nx;
  logic [7:0] sj, sj_nx;
  logic [7:0] f, f_nx;
  logic [7:0] e, e_nx;
  logic [MSG_AW-1:0] k, k_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      f     <= '0;
      e     <= '0;
    end else begin
      state <= state_nx;
      i     <= i_nx;
      j     <= j_nx;
      k     <= k_nx;
      si    <= si_nx;
      sj    <= sj_nx;
      f     <= f_nx;
      e     <= e_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    i_nx      = i;
    j_nx      = j;
    k_nx      = k;
    si_nx     = si;
    sj_nx     = sj;
    f_nx      = f;
    e_nx      = e;
    fin       = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    enc_addr  = '0;
    dec_addr  = '0;
    dec_wdata = '0;
    dec_wren  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          i_nx     = i + 8'd1;
          state_nx = RD_SI;
        end
      end
      RD_SI: begin
        s_addr   = i;
        state_nx = CAP_SI;
      end
      CAP_SI: begin
        si_nx    = s_rdata;
        j_nx     = j + s_rdata;
        state_nx = RD_SJ;
      end
      RD_SJ: begin
        s_addr   = j;
        state_nx = CAP_SJ;
      end
      CAP_SJ: begin
        sj_nx    = s_rdata;
        state_nx = WR_I;
      end
      WR_I: begin
        s_addr   = i;
        s_wdata  = sj;
        s_wren   = 1'b1;
        state_nx = WR_J;
      end
      // Swap completes here, so the RD_F read sees the new contents.
      WR_J: begin
        s_addr   = j;
        s_wdata  = si;
        s_wren   = 1'b1;
        state_nx = RD_F;
      end
      RD_F: begin
        s_addr   = si + sj;
        enc_addr = k;
        state_nx = CAP_F;
      end
      CAP_F: begin
        f_nx     = s_rdata;
        e_nx     = enc_rdata;
        state_nx = WR_D;
      end
      WR_D: begin
        dec_addr  = k;
        dec_wdata = f ^ e;
        dec_wren  = 1'b1;
        if (k == K_LAST) begin
          state_nx = DONE;
        end else begin
          k_nx     = k + 1'b1;
          i_nx     = i + 8'd1;
          state_nx = RD_SI;
        end
      end
      DONE: begin
        fin = 1'b1;
        if (!start) begin
          i_nx     = '0;
          j_nx     = '0;
          k_nx     = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
